universal_shift_register_n: RTL
===============================

// Module: universal_shift_register_n
// PURPOSE
//   WIDTH-bit universal shift register with a multi-cycle shift-by-N command.
//   Commands: hold, shift right, shift left, parallel load; start/busy/done handshake.
//   Serial-out bit is exposed for cascading.
//   Drop-in upgrade for the 4-bit single-step universal shift register in the datapath.
// PARAMETERS
//   WIDTH  4                      register width, >=2
//   CNT_W  $clog2(WIDTH+1) (=3)   width of shift-count input
// PORTS
//   clk    in   1      single clock, rising edge
//   clr    in   1      reset: synchronous, active-high
//   start  in   1      command strobe, sampled only when busy=0
//   mode   in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   cnt    in   CNT_W  shift count (shift modes only)
//   sin    in   1      serial input, sampled on every shift edge
//   rot    in   1      rotate select (used only with ROTATE_EN)
//   p_in   in   WIDTH  parallel load data
//   out    out  WIDTH  register contents
//   sout   out  1      last bit shifted out (registered)
//   busy   out  1      multi-cycle shift in progress
//   done   out  1      one-cycle pulse: command complete
// BEHAVIOUR
//   - Reset (clr=1 at edge) has priority over everything, including mid-shift.
//     Result: out=0, sout=0, busy=0, done=0, state=IDLE, remaining count=0.
//   - Shift right, one step: out[0]<=sin, out[i]<=out[i-1], sout<=old out[WIDTH-1].
//   - Shift left, one step: out[WIDTH-1]<=sin, out[i]<=out[i+1], sout<=old out[0].
//   - FSM states: IDLE, SHIFT. busy = (state==SHIFT).
//   - In IDLE, start=1 accepts the command at that edge (done from a prior command does not block).
//   - Hold, or shift with cnt=0: out unchanged, done=1 next cycle, stay IDLE.
//   - Parallel load: out<=p_in, done=1 next cycle, stay IDLE; sout unchanged.
//   - Shift with cnt=1: one step at the accept edge, done=1 next cycle, stay IDLE.
//   - Shift with cnt>1:
//       - One step at the accept edge; latch direction (and rot); remaining<=cnt-1; go to SHIFT.
//       - In SHIFT: one step per cycle, remaining decrements.
//       - On the edge where remaining==1: final step, done<=1, go to IDLE.
//   - Total shift edges = cnt. done is high the cycle after the last shift edge.
//   - cnt>WIDTH is legal: the register fully fills with sin samples.
//   - While busy: start, mode, cnt, rot and p_in are ignored; sin is still sampled each step.
//   - done is high exactly one cycle per accepted command.
//   - start in the same cycle done is high (state IDLE) is accepted, giving back-to-back commands.
// CONFIGURATION
//   - ROTATE_EN defined:
//       - rot=1 at accept makes the shift a rotate: the bit shifted out is fed in instead of sin.
//       - sout still reports the bit shifted out.
//   - ROTATE_EN undefined: rot is ignored; all shifts take sin.
// STRUCTURE
//   - Package usr_pkg holds:
//       - typedef enum logic[1:0] usr_mode_t {MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD}
//       - typedef enum logic usr_state_t {ST_IDLE, ST_SHIFT}
//   - Sub-module usr_shift_cnt: CNT_W down-counter.
//       - Inputs: load, value, dec. Output: last (remaining==1).
//   - Datapath shift step and FSM stay in the top module.
// TESTING (WIDTH=4)
//   - Reset mid-shift: shift right cnt=3, assert clr on the 2nd busy cycle.
//       -> next cycle out=0000, busy=0, done=0, sout=0.
//   - Load: mode=11, p_in=1011, start.
//       -> next cycle out=1011, done=1 for 1 cycle, busy=0.
//   - Shift right: from 1011, mode=01, cnt=2, sin=0 then 1.
//       -> out=0110 then 1101; busy high 1 cycle; done after 2nd step; sout=0 (last bit out).
//   - Shift left: from 1011, mode=10, cnt=4, sin=1 each step.
//       -> out=1111 after 4 edges; start/mode changes while busy have no effect.
//   - cnt=0 and hold: out unchanged, done pulses next cycle.
//       Then start held on the done cycle -> second command accepted back-to-back.
//   - ROTATE_EN: from 1000, shift right, rot=1, cnt=5.
//       -> out=0001 after 5 edges; without the macro, same stimulus with sin=0 -> out=0000.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the universal shift register
package usr_pkg;
   typedef enum logic [1:0] {MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD} usr_mode_t;
   typedef enum logic {ST_IDLE, ST_SHIFT} usr_state_t;
endpackage

// File: rtl/universal_shift_register_n_if.sv
// universal_shift_register_n_if: command/data bus of the universal shift register
interface universal_shift_register_n_if import usr_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
);
   logic             start;
   usr_mode_t        mode;
   logic [CNT_W-1:0] cnt;
   logic             sin;
   logic             rot;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] out;
   logic             sout;
   logic             busy;
   logic             done;
   modport master (output start, mode, cnt, sin, rot, p_in, input out, sout, busy, done);
   modport slave  (input start, mode, cnt, sin, rot, p_in, output out, sout, busy, done);
endinterface

// File: rtl/usr_shift_cnt.sv
// usr_shift_cnt: remaining-step down-counter, last flags one step left
module usr_shift_cnt #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] value,
   output logic             last
);
   logic [CNT_W-1:0] rem;
   // load takes priority over decrement
   always_ff @(posedge clk) rem <= clr ? '0 : load ? value : dec ? rem - CNT_W'(1) : rem;
   assign last = rem == CNT_W'(1);
endmodule

// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n: WIDTH-bit universal shift register with shift-by-N (optional rotate via ROTATE_EN)
module universal_shift_register_n import usr_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic clk,
   input logic clr,
   universal_shift_register_n_if.slave bus
);
   usr_state_t state, nxt_state;
   logic [WIDTH-1:0] sr, nxt_sr;
   logic sout_q, nxt_sout, done_q, nxt_done, dir_q, last;
   logic accept, is_shift, multi, step, dir, rot_eff, fill;
`ifdef ROTATE_EN
   logic rot_q;
   // rotate select is latched with the direction at accept
   always_ff @(posedge clk) rot_q <= clr ? 1'b0 : (accept ? bus.rot : rot_q);
   assign rot_eff = state == ST_SHIFT ? rot_q : bus.rot;
`else
   assign rot_eff = 1'b0;
`endif
   assign accept   = state == ST_IDLE && bus.start;
   assign is_shift = bus.mode == MODE_SHR || bus.mode == MODE_SHL;
   assign multi    = accept && is_shift && bus.cnt > CNT_W'(1);
   assign step     = state == ST_SHIFT || (accept && is_shift && bus.cnt != '0);
   assign dir      = state == ST_SHIFT ? dir_q : bus.mode == MODE_SHL;
   assign fill     = rot_eff ? (dir ? sr[0] : sr[WIDTH-1]) : bus.sin;
   usr_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .clr   (clr),
      .load  (multi),
      .dec   (state == ST_SHIFT),
      .value (bus.cnt - CNT_W'(1)),
      .last  (last)
   );
   // next-state, shift step and done generation
   always_comb begin
      nxt_state = state;
      nxt_sr    = sr;
      nxt_sout  = sout_q;
      nxt_done  = 1'b0;
      if (step) begin
         nxt_sr   = dir ? {fill, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], fill};
         nxt_sout = dir ? sr[0] : sr[WIDTH-1];
      end else if (accept && bus.mode == MODE_LOAD) nxt_sr = bus.p_in;
      if (multi) nxt_state = ST_SHIFT;
      else if (accept) nxt_done = 1'b1;
      if (state == ST_SHIFT && last) begin
         nxt_state = ST_IDLE;
         nxt_done  = 1'b1;
      end
   end
   // state and datapath registers, reset overrides everything
   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= ST_IDLE;
         sr     <= '0;
         sout_q <= 1'b0;
         done_q <= 1'b0;
         dir_q  <= 1'b0;
      end else begin
         state  <= nxt_state;
         sr     <= nxt_sr;
         sout_q <= nxt_sout;
         done_q <= nxt_done;
         dir_q  <= accept ? bus.mode == MODE_SHL : dir_q;
      end
   end
   assign bus.out  = sr;
   assign bus.sout = sout_q;
   assign bus.busy = state == ST_SHIFT;
   assign bus.done = done_q;
endmodule
